// File: rtl/easy6502_io_pkg.sv
// easy6502 I/O responder shared definitions.
// Addresses, LFSR taps and RX FSM encoding.
package easy6502_io_pkg;

  localparam logic [15:0] IO_RNG_ADDR = 16'h00FE;
  localparam logic [15:0] IO_KEY_ADDR = 16'h00FF;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  localparam logic [2:0] RX_WAIT_IDLE = 3'd0;
  localparam logic [2:0] RX_IDLE      = 3'd1;
  localparam logic [2:0] RX_START     = 3'd2;
  localparam logic [2:0] RX_DATA      = 3'd3;
  localparam logic [2:0] RX_STOP      = 3'd4;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/easy6502_io_uart_rx.sv
// 8N1 serial receiver with input synchroniser.
// Emits one-cycle byte_valid / frame_err pulses.
module uart_rx
  import easy6502_io_pkg::*;
#(
  parameter int BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] SETTLE = CW'(2);

  logic          s1;
  logic          s2;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  assign byte_data = shift;

  // Two-flop synchroniser for the asynchronous line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
    end
  end

  // Frame FSM; sync flops reset high, so WAIT_IDLE
  // lets real line values flush through first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RX_WAIT_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_WAIT_IDLE: begin
          if (cnt < SETTLE) begin
            cnt <= cnt + 1'b1;
          end else if (s2) begin
            cnt   <= '0;
            state <= RX_IDLE;
          end
        end
        RX_IDLE: begin
          if (!s2) begin
            cnt   <= '0;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            if (s2) begin
              state <= RX_IDLE;
            end else begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= RX_DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= s2;
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (s2) begin
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RX_WAIT_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/easy6502_io.sv
// easy6502 memory-mapped I/O: $FE random, $FF key.
// Read data is registered to match RAM latency.
module easy6502_io
  import easy6502_io_pkg::*;
#(
  parameter int          CLK_HZ    = 25000000,
  parameter int          BAUD      = 115200,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_ready,
  input  logic        uart_rx,
  output logic        io_hit,
  output logic [7:0]  io_rdata,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;

  logic [15:0] lfsr;
  logic [7:0]  key;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        is_rng;
  logic        is_key;

  assign is_rng = (cpu_addr == IO_RNG_ADDR);
  assign is_key = (cpu_addr == IO_KEY_ADDR);

  uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (uart_rx),
    .byte_data (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (frame_err)
  );

  // Free-running Galois LFSR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Key register; a received byte beats a CPU write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key        <= '0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= rx_valid;
      if (rx_valid) begin
        key <= rx_byte;
      end else if (cpu_ready && cpu_we && is_key) begin
        key <= cpu_wdata;
      end
    end
  end

  // Registered bus read response; holds while RDY low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_hit   <= 1'b0;
      io_rdata <= '0;
    end else if (cpu_ready) begin
      if (cpu_we) begin
        io_hit <= 1'b0;
      end else begin
        io_hit <= is_rng | is_key;
        unique case (1'b1)
          is_rng:  io_rdata <= lfsr[7:0];
          is_key:  io_rdata <= key;
          default: io_rdata <= '0;
        endcase
      end
    end
  end

endmodule
